fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the CPU's `instr` input.
- Owns the PC and issues word reads to the shared memory, which has a registered read (data valid 1 cycle after `mem_read`).
- Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Takes branch/jump redirects from the CPU and discards wrong-path words.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2.
- ADDR_W, 32, address/PC width.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  output  1  read strobe to memory, one word per cycle.
- mem_addr  output  ADDR_W  byte address of read; always 4-byte aligned.
- mem_data  input  32  read data, valid the cycle after `mem_read`.
- redirect_valid  input  1  CPU requests a PC change (branch/jump taken).
- redirect_pc  input  ADDR_W  new PC; bits [1:0] ignored (forced 0).
- halt  input  1  stop issuing new fetches (e.g. ebreak/debug).
- instr  output  32  instruction word at FIFO head.
- instr_pc  output  ADDR_W  PC of `instr`.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  CPU consumes head this cycle when `instr_valid` is high.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, FIFO empty, inflight=0, epoch=0, state=S_IDLE.
  - mem_read=0, mem_addr=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0.
- FSM states S_IDLE, S_RUN, S_HALT:
  - S_IDLE → S_RUN on the first clock after reset release; no fetch is issued in S_IDLE.
  - S_RUN → S_HALT when halt=1.
  - S_HALT → S_RUN when halt=0.
  - redirect_valid is honoured in every state.
- Issue rule, evaluated in S_RUN:
  - mem_read=1 iff (count + inflight) < FIFO_DEPTH and redirect_valid=0.
  - mem_addr=pc; on issue, pc<=pc+4 (wraps modulo 2^ADDR_W), inflight<=1, req_pc<=pc, req_epoch<=epoch.
- Response:
  - The cycle after an issue, mem_data is pushed with req_pc, but only if req_epoch==epoch; otherwise it is dropped.
  - Credit accounting guarantees the push never overflows.
- Latency: issue at cycle N, response pushed at N+1, instr_valid high at N+2 when the FIFO was empty (registered FIFO output).
  - Sustained throughput is 1 instr/cycle with instr_ready held high.
- Handshake:
  - Pop on instr_valid & instr_ready.
  - instr/instr_pc are stable while instr_valid=1 and instr_ready=0.
  - Push and pop in the same cycle leave count unchanged; push into an empty FIFO with a same-cycle pop is not a bypass.
- Redirect (redirect_valid=1):
  - FIFO flushed (count=0, instr_valid=0 next cycle), pc<=redirect_pc&~3, epoch toggles.
  - No issue in the redirect cycle; fetching resumes from the new pc the following cycle, even in S_HALT (pc updates, issue waits for halt=0).
  - A response arriving in the redirect cycle or the next is dropped by the epoch mismatch.
  - Simultaneous redirect and pop: redirect wins; pop is ignored.
- Full: no issue while count+inflight==FIFO_DEPTH.
- Empty: instr_valid=0; instr holds its last value.
- Halt: in-flight response still completes and is pushed; the FIFO continues draining to the CPU.
- Reset mid-operation: everything returns immediately to reset values; the pending response is ignored (inflight cleared).

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched[31:0] (words pushed), perf_dropped[31:0] (epoch-dropped responses) and perf_stall[31:0] (cycles in S_RUN with no issue because of full credit).
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_t enum (S_IDLE, S_RUN, S_HALT);
  - the NOP_INSTR constant 32'h0000_0013;
  - the fetch_entry_t struct {instr[31:0], pc[ADDR_W-1:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, and registered head output.

Test Plan:
- Reset release, instr_ready=1, memory word at address k = 32'hA000_0000+k → mem_addr 0,4,8,… on consecutive cycles; instr 32'hA000_0000, 32'hA000_0004, … with instr_pc 0,4,8; first instr_valid 3 cycles after reset release.
- instr_ready=0 for 10 cycles → exactly 4 issues, then mem_read=0; instr holds 32'hA000_0000; releasing instr_ready resumes 1 pop/cycle with no loss or duplicates.
- redirect_valid=1 with redirect_pc=32'h0000_0103 while the FIFO holds 3 entries and 1 is in flight → next cycle instr_valid=0; next mem_addr=32'h0000_0100; the in-flight word never appears; the first delivered instr_pc=32'h100.
- halt=1 mid-stream → mem_read=0 from the next cycle; the in-flight word is delivered; halt=0 → fetch resumes at the correct next pc.
- pc=32'hFFFF_FFFC with a sequential fetch → next mem_addr=32'h0000_0000.
- Reset asserted while 2 entries are buffered → instr_valid=0 and mem_read=0 immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   PC_W          : width of a program counter / byte address
//   NOP_INSTR     : instruction shown on instr before anything is fetched
//   fetch_state_t : fetch FSM states (S_IDLE, S_RUN, S_HALT)
//   fetch_entry_t : one prefetch FIFO entry {instr, pc}
//   ENTRY_W       : packed width of fetch_entry_t
//   align_word()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t with a registered head output.
// The head register keeps its last value when the FIFO drains or is flushed,
// so the consumer sees a stable word even while head_valid is low.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   push, push_data     : write one entry (ignored when full without a pop)
//   pop                 : remove the head entry (ignored when empty)
//   flush               : discard all entries; wins over push and pop
//   count               : number of stored entries
//   head, head_valid    : registered head entry and its valid flag
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [ENTRY_W-1:0]     push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [ENTRY_W-1:0]     head,
    output logic                   head_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     head_q;
    fetch_entry_t     head_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    // Work out what the head register must hold after this edge. If the
    // pushed word ends up as the only entry it goes straight into the head
    // register; otherwise the new head is already sitting in storage.
    always_comb begin
        do_pop     = pop && (count_q != '0);
        do_push    = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
        count_nxt  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_nxt   = head_q;
        if (do_push && (count_nxt == CNT_W'(1))) begin
            head_nxt = push_data;
        end else if (count_nxt != '0) begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Pointers, occupancy and head register; flush empties the FIFO but
    // leaves the head register holding the last delivered word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '{instr: NOP_INSTR, pc: RESET_PC};
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            head_q  <= head_nxt;
        end
    end

    // Entry storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign count      = count_q;
    assign head       = head_q;
    assign head_valid = (count_q != '0);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues one word read per cycle to a
// memory with a registered read port, buffers the returned words in a
// prefetch FIFO and presents them to decode over instr_valid/instr_ready.
// Redirects flush the FIFO and retag outstanding requests via an epoch bit.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   mem_read, mem_addr         : word read request (address 4-byte aligned)
//   mem_data                   : read data, valid the cycle after mem_read
//   redirect_valid, redirect_pc: branch/jump target from the CPU
//   halt                       : stop issuing new fetches
//   instr, instr_pc            : FIFO head word and its PC
//   instr_valid, instr_ready   : handshake towards decode
//   perf_fetched/dropped/stall : saturating event counters, present only
//                                when FETCH_PERF_EN is defined
// ADDR_W must match fetch_pkg::PC_W, which sizes the FIFO entry.
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4,
    parameter int              ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              epoch;
    logic              req_epoch;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              credit_full;
    logic              issue;
    logic              resp_push;
    logic              fifo_pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; redirects are handled in the datapath and do
    // not change the state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN:   if (halt)  state_nxt = S_HALT;
            S_HALT:  if (!halt) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs. A fetch is only issued when the FIFO is guaranteed room
    // for it counting the word still on its way back from memory, so the
    // response can always be pushed.
    always_comb begin
        credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
        credit_full = (credit_used >= (CNT_W+1)'(FIFO_DEPTH));
        issue       = (state == S_RUN) && !credit_full && !redirect_valid;
        mem_read    = issue;
        mem_addr    = pc;
    end

    // PC, outstanding-request tracking and epoch. A redirect bumps the epoch
    // so a response tagged with the old epoch can never be pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                pc    <= align_word(redirect_pc);
                epoch <= ~epoch;
            end else if (issue) begin
                pc        <= pc + ADDR_W'(4);
                req_pc    <= pc;
                req_epoch <= epoch;
            end
        end
    end

    // A response landing in the redirect cycle belongs to the old path and
    // would be wiped by the flush anyway; it is not counted as pushed.
    always_comb begin
        resp_push  = inflight && (req_epoch == epoch) && !redirect_valid;
        fifo_pop   = instr_valid && instr_ready;
        push_entry = '{instr: mem_data, pc: req_pc};
    end

    fetch_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (resp_push),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head       (head_entry),
        .head_valid (instr_valid)
    );

    assign instr    = head_entry.instr;
    assign instr_pc = head_entry.pc;

`ifdef FETCH_PERF_EN
    logic resp_drop;
    logic stall_cycle;

    assign resp_drop   = inflight && !resp_push;
    assign stall_cycle = (state == S_RUN) && credit_full && !redirect_valid;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (resp_push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (resp_drop && (perf_dropped != '1)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (stall_cycle && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The memory model returns 32'hA000_0000 plus
// the byte address one cycle after each read. Inputs change 1ns after the
// rising edge and outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    int check_count = 0;
    int fail_count  = 0;

    typedef struct {
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        halt;
        logic        ready;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [16];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall)
`endif
    );

    // Free-running 10ns clock.
    always #5 clk = ~clk;

    // Memory with a registered read port.
    always @(posedge clk) begin
        if (mem_read) begin
            mem_data <= 32'hA000_0000 + mem_addr;
        end
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        redirect_valid = v.redirect;
        redirect_pc    = v.redirect_pc;
        halt           = v.halt;
        instr_ready    = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        checkOutput({tag, " mem_read"},    {31'b0, mem_read},    {31'b0, v.exp_read});
        checkOutput({tag, " mem_addr"},    mem_addr,             v.exp_addr);
        checkOutput({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, v.exp_valid});
        checkOutput({tag, " instr"},       instr,                v.exp_instr);
        checkOutput({tag, " instr_pc"},    instr_pc,             v.exp_pc);
    endtask

    initial begin
        int          issues;
        logic [31:0] exp_pc;

        // Per-cycle vectors from reset release: streaming with instr_ready
        // high, then halt for four cycles and resume.
        //          redir pc    halt rdy  read addr         valid instr          pc
        vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h00};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h00};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0013, 32'h00};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'hA000_0000, 32'h00};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'hA000_0004, 32'h04};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'hA000_0008, 32'h08};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'hA000_000C, 32'h0C};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'hA000_0010, 32'h10};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'hA000_0014, 32'h14};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b1, 32'hA000_0018, 32'h18};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b1, 32'hA000_001C, 32'h1C};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b0, 32'hA000_001C, 32'h1C};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 1'b0, 32'hA000_001C, 32'h1C};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b0, 32'hA000_001C, 32'h1C};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0024, 1'b0, 32'hA000_001C, 32'h1C};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0028, 1'b1, 32'hA000_0020, 32'h20};

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        instr_ready    = 1'b0;

        // Values held while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem_read",    {31'b0, mem_read},    32'h0);
        checkOutput("reset mem_addr",    mem_addr,             32'h0);
        checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("reset instr",       instr,                32'h0000_0013);
        checkOutput("reset instr_pc",    instr_pc,             32'h0);

        // Streaming and halt, driven from the vector table.
        for (int i = 0; i < 16; i++) begin
            if (i > 0) nextCycle();
            applyStimulus(vecs[i]);
            if (i == 0) reset = 1'b1;
            #1;
            checkVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Restart with decode stalled: exactly four fetches fill the FIFO.
        nextCycle();
        reset       = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        #1;
        issues = 0;
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            #1;
            if (mem_read) issues++;
            if (c >= 3) begin
                checkOutput($sformatf("stall%0d instr", c), instr, 32'hA000_0000);
                checkOutput($sformatf("stall%0d valid", c), {31'b0, instr_valid}, 32'h1);
            end
        end
        checkOutput("stall issue count", issues, 32'd4);
        checkOutput("stall mem_read",    {31'b0, mem_read}, 32'h0);
        checkOutput("stall mem_addr",    mem_addr, 32'h10);

        // Release decode: twelve back-to-back in-order pops.
        instr_ready = 1'b1;
        exp_pc      = 32'h0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                nextCycle();
                #1;
            end
            checkOutput($sformatf("resume%0d valid", k), {31'b0, instr_valid}, 32'h1);
            checkOutput($sformatf("resume%0d pc", k), instr_pc, exp_pc);
            checkOutput($sformatf("resume%0d instr", k), instr, 32'hA000_0000 + exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        nextCycle();
        instr_ready = 1'b0;
        repeat (8) nextCycle();
        #1;
        checkOutput("refill head pc", instr_pc, 32'h30);
        checkOutput("refill mem_read", {31'b0, mem_read}, 32'h0);

        // Redirect with three buffered entries and one fetch in flight.
        instr_ready = 1'b1;
        nextCycle();
        instr_ready = 1'b0;
        #1;
        checkOutput("pre-redirect mem_read", {31'b0, mem_read}, 32'h1);
        checkOutput("pre-redirect mem_addr", mem_addr, 32'h40);
        nextCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        instr_ready    = 1'b1;
        #1;
        checkOutput("redirect mem_read",    {31'b0, mem_read}, 32'h0);
        checkOutput("redirect instr_valid", {31'b0, instr_valid}, 32'h1);
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checkOutput("redirect+1 valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("redirect+1 mem_read", {31'b0, mem_read}, 32'h1);
        checkOutput("redirect+1 mem_addr", mem_addr, 32'h100);
        nextCycle();
        #1;
        checkOutput("redirect+2 valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("redirect+2 mem_addr", mem_addr, 32'h104);
        nextCycle();
        #1;
        checkOutput("redirect+3 valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("redirect+3 pc", instr_pc, 32'h100);
        checkOutput("redirect+3 instr", instr, 32'hA000_0100);

        // PC wrap at the top of the address space.
        nextCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        checkOutput("wrap redirect mem_read", {31'b0, mem_read}, 32'h0);
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checkOutput("wrap+1 valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("wrap+1 mem_addr", mem_addr, 32'hFFFF_FFFC);
        nextCycle();
        #1;
        checkOutput("wrap+2 mem_addr", mem_addr, 32'h0);
        nextCycle();
        #1;
        checkOutput("wrap+3 pc", instr_pc, 32'hFFFF_FFFC);
        checkOutput("wrap+3 instr", instr, 32'h9FFF_FFFC);
        nextCycle();
        #1;
        checkOutput("wrap+4 pc", instr_pc, 32'h0);
        checkOutput("wrap+4 instr", instr, 32'hA000_0000);

        // Asynchronous reset with two entries buffered and one in flight.
        nextCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        instr_ready    = 1'b0;
        nextCycle();
        redirect_valid = 1'b0;
        repeat (3) nextCycle();
        #1;
        checkOutput("pre-reset valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("pre-reset pc", instr_pc, 32'h200);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async reset valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("async reset mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("async reset mem_addr", mem_addr, 32'h0);
        checkOutput("async reset instr", instr, 32'h0000_0013);
        checkOutput("async reset instr_pc", instr_pc, 32'h0);
        nextCycle();
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nextCycle();
            applyStimulus(vecs[i]);
            if (i == 0) reset = 1'b1;
            #1;
            checkVector(vecs[i], $sformatf("restart%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
